// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus bundle.
// Groups the three requester channels (fetch, exec, dbg), the memory-side
// bus (addr/data_out/we/data_in) and the arbiter status outputs
// (rdata, per-requester ready, one-hot grant {dbg, exec, fetch}).
//   master : requesters and memory model (drive requests and data_in)
//   slave  : the arbiter (drives the bus and the status outputs)
interface mem_arbiter_if;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       exec_req;
  logic [7:0] exec_addr;
  logic       exec_we;
  logic [7:0] exec_wdata;
  logic       dbg_req;
  logic [7:0] dbg_addr;
  logic       dbg_we;
  logic [7:0] dbg_wdata;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       we;
  logic [7:0] rdata;
  logic       fetch_ready;
  logic       exec_ready;
  logic       dbg_ready;
  logic [2:0] grant;

  modport master (
    output fetch_req, fetch_addr,
    output exec_req, exec_addr, exec_we, exec_wdata,
    output dbg_req, dbg_addr, dbg_we, dbg_wdata,
    output data_in,
    input  addr, data_out, we, rdata,
    input  fetch_ready, exec_ready, dbg_ready, grant
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  exec_req, exec_addr, exec_we, exec_wdata,
    input  dbg_req, dbg_addr, dbg_we, dbg_wdata,
    input  data_in,
    output addr, data_out, we, rdata,
    output fetch_ready, exec_ready, dbg_ready, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter and access sequencer for the 8-bit
// memory bus (fetch, execute, debug/loader).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_arbiter_if.slave: requester channels, memory bus, rdata,
//          per-requester ready and one-hot grant {dbg, exec, fetch}
// Each access holds the bus for WAIT_STATES+1 cycles, then raises the
// owner's ready until the owner drops its request.
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requests
// ACCESS | bus driven for the owner; wait counter runs
// DONE   | owner's ready high; waiting for the owner to drop req
module mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] ready_q, ready_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] rdata_q, rdata_d;
  logic       we_q, we_d;

  logic [2:0] req_vec;
  logic [2:0] pick;

  assign req_vec = {bus.dbg_req, bus.exec_req, bus.fetch_req};

  // Round-robin: search starts at the requester after the last owner.
  always_comb begin
    pick = 3'b000;
    case (last_q)
      3'b001: begin
        if      (req_vec[1]) pick = 3'b010;
        else if (req_vec[2]) pick = 3'b100;
        else if (req_vec[0]) pick = 3'b001;
      end
      3'b010: begin
        if      (req_vec[2]) pick = 3'b100;
        else if (req_vec[0]) pick = 3'b001;
        else if (req_vec[1]) pick = 3'b010;
      end
      default: begin
        if      (req_vec[0]) pick = 3'b001;
        else if (req_vec[1]) pick = 3'b010;
        else if (req_vec[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ready_d    = ready_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    rdata_d    = rdata_q;
    we_d       = we_q;

    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = 3'd0;
          state_d = ACCESS;
          case (pick)
            3'b001: begin
              // Fetch is read-only: nothing to drive on the write path.
              addr_d     = bus.fetch_addr;
              data_out_d = 8'h00;
              we_d       = 1'b0;
            end
            3'b010: begin
              addr_d     = bus.exec_addr;
              data_out_d = bus.exec_wdata;
              we_d       = bus.exec_we;
            end
            default: begin
              addr_d     = bus.dbg_addr;
              data_out_d = bus.dbg_wdata;
              we_d       = bus.dbg_we;
            end
          endcase
        end else begin
          grant_d = 3'b000;
          we_d    = 1'b0;
          ready_d = 3'b000;
        end
      end
      ACCESS: begin
        if (cnt_q < WS) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          // Read data is captured on writes too; harmless and keeps rdata simple.
          rdata_d = bus.data_in;
          ready_d = grant_q;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!(|(grant_q & req_vec))) begin
          ready_d = 3'b000;
          grant_d = 3'b000;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      last_q     <= 3'b100;
      grant_q    <= 3'b000;
      ready_q    <= 3'b000;
      addr_q     <= 8'h00;
      data_out_q <= 8'h00;
      rdata_q    <= 8'h00;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.data_out    = data_out_q;
  assign bus.we          = we_q;
  assign bus.rdata       = rdata_q;
  assign bus.grant       = grant_q;
  assign bus.fetch_ready = ready_q[0];
  assign bus.exec_ready  = ready_q[1];
  assign bus.dbg_ready   = ready_q[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with WAIT_STATES=1 (dut 0) and one
// with WAIT_STATES=0 (dut 1), each compared every cycle against a
// transaction-level reference model, plus directed constant checks.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.WAIT_STATES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_arbiter #(.WAIT_STATES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Stimulus per dut, requester index 0=fetch 1=exec 2=dbg.
  logic       req_v  [2][3];
  logic [7:0] addr_v [2][3];
  logic       we_v   [2][3];
  logic [7:0] wd_v   [2][3];
  logic [7:0] din_v  [2];

  assign bus0.fetch_req  = req_v[0][0];
  assign bus0.fetch_addr = addr_v[0][0];
  assign bus0.exec_req   = req_v[0][1];
  assign bus0.exec_addr  = addr_v[0][1];
  assign bus0.exec_we    = we_v[0][1];
  assign bus0.exec_wdata = wd_v[0][1];
  assign bus0.dbg_req    = req_v[0][2];
  assign bus0.dbg_addr   = addr_v[0][2];
  assign bus0.dbg_we     = we_v[0][2];
  assign bus0.dbg_wdata  = wd_v[0][2];
  assign bus0.data_in    = din_v[0];

  assign bus1.fetch_req  = req_v[1][0];
  assign bus1.fetch_addr = addr_v[1][0];
  assign bus1.exec_req   = req_v[1][1];
  assign bus1.exec_addr  = addr_v[1][1];
  assign bus1.exec_we    = we_v[1][1];
  assign bus1.exec_wdata = wd_v[1][1];
  assign bus1.dbg_req    = req_v[1][2];
  assign bus1.dbg_addr   = addr_v[1][2];
  assign bus1.dbg_we     = we_v[1][2];
  assign bus1.dbg_wdata  = wd_v[1][2];
  assign bus1.data_in    = din_v[1];

  logic [7:0] o_addr  [2];
  logic [7:0] o_dout  [2];
  logic       o_we    [2];
  logic [7:0] o_rdata [2];
  logic [2:0] o_rdy   [2];
  logic [2:0] o_grant [2];

  assign o_addr[0]  = bus0.addr;
  assign o_dout[0]  = bus0.data_out;
  assign o_we[0]    = bus0.we;
  assign o_rdata[0] = bus0.rdata;
  assign o_rdy[0]   = {bus0.dbg_ready, bus0.exec_ready, bus0.fetch_ready};
  assign o_grant[0] = bus0.grant;
  assign o_addr[1]  = bus1.addr;
  assign o_dout[1]  = bus1.data_out;
  assign o_we[1]    = bus1.we;
  assign o_rdata[1] = bus1.rdata;
  assign o_rdy[1]   = {bus1.dbg_ready, bus1.exec_ready, bus1.fetch_ready};
  assign o_grant[1] = bus1.grant;

  // Reference model: who owns the bus, how many edges since the grant,
  // and the expected visible outputs.
  int         ws      [2] = '{1, 0};
  int         m_owner [2];
  int         m_age   [2];
  bit         m_done  [2];
  int         m_last  [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_dout  [2];
  logic       m_we    [2];
  logic [7:0] m_rdata [2];
  logic [2:0] m_rdy   [2];
  logic [2:0] m_grant [2];

  int n_cmp;
  int n_fail;
  int cyc;
  logic [2:0] prev_grant [2];
  int glog0 [$];
  int glog1 [$];
  int gt1   [$];
  bit dropped [3];
  int cnt_we;
  bit seen;
  int exp_order [6] = '{1, 2, 4, 1, 2, 4};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, int d, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %02h expected %02h", tag, d, obs, exp);
    end
  endtask

  task automatic model(int d);
    int found;
    if (rst) begin
      m_owner[d] = -1; m_age[d] = 0; m_done[d] = 0; m_last[d] = 2;
      m_addr[d] = 8'h00; m_dout[d] = 8'h00; m_we[d] = 1'b0;
      m_rdata[d] = 8'h00; m_rdy[d] = 3'b000; m_grant[d] = 3'b000;
    end else if (m_owner[d] < 0) begin
      found = -1;
      for (int k = 1; k <= 3; k++)
        if (found < 0 && req_v[d][(m_last[d] + k) % 3]) found = (m_last[d] + k) % 3;
      if (found >= 0) begin
        m_owner[d] = found; m_last[d] = found; m_age[d] = 0; m_done[d] = 0;
        m_addr[d]  = addr_v[d][found];
        m_dout[d]  = (found == 0) ? 8'h00 : wd_v[d][found];
        m_we[d]    = (found == 0) ? 1'b0 : we_v[d][found];
        m_grant[d] = 3'(1 << found);
      end else begin
        m_grant[d] = 3'b000; m_we[d] = 1'b0; m_rdy[d] = 3'b000;
      end
    end else if (!m_done[d]) begin
      if (m_age[d] == ws[d]) begin
        m_rdata[d] = din_v[d];
        m_rdy[d]   = 3'(1 << m_owner[d]);
        m_we[d]    = 1'b0;
        m_done[d]  = 1;
      end else begin
        m_age[d]++;
      end
    end else if (!req_v[d][m_owner[d]]) begin
      m_rdy[d] = 3'b000; m_grant[d] = 3'b000; m_owner[d] = -1;
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) model(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      chk("addr", d, o_addr[d], m_addr[d]);
      chk("data_out", d, o_dout[d], m_dout[d]);
      chk("we", d, 8'(o_we[d]), 8'(m_we[d]));
      chk("rdata", d, o_rdata[d], m_rdata[d]);
      chk("ready", d, 8'(o_rdy[d]), 8'(m_rdy[d]));
      chk("grant", d, 8'(o_grant[d]), 8'(m_grant[d]));
      if (o_grant[d] != 3'b000 && prev_grant[d] == 3'b000) begin
        if (d == 0) glog0.push_back(int'(o_grant[d]));
        else begin
          glog1.push_back(int'(o_grant[d]));
          gt1.push_back(cyc);
        end
      end
      prev_grant[d] = o_grant[d];
    end
  endtask

  task automatic clear_stim();
    for (int d = 0; d < 2; d++) begin
      din_v[d] = 8'h00;
      for (int i = 0; i < 3; i++) begin
        req_v[d][i] = 1'b0; addr_v[d][i] = 8'h00; we_v[d][i] = 1'b0; wd_v[d][i] = 8'h00;
      end
    end
    for (int i = 0; i < 3; i++) dropped[i] = 0;
  endtask

  task automatic reset_all();
    clear_stim();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Requester reaction: drop req on ready, re-raise the cycle after.
  task automatic react(int d, int i);
    if (dropped[i]) begin
      req_v[d][i] = 1'b1; dropped[i] = 0;
    end else if (o_rdy[d][i]) begin
      req_v[d][i] = 1'b0; dropped[i] = 1;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    prev_grant[0] = 3'b000; prev_grant[1] = 3'b000;
    clear_stim();
    rst = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_grant", 0, 8'(o_grant[0]), 8'h00);
    chk("rst_addr", 0, o_addr[0], 8'h00);
    rst = 1'b0;

    // Single fetch read
    din_v[0] = 8'hA5; addr_v[0][0] = 8'h3C; req_v[0][0] = 1'b1;
    step();
    chk("fetch_addr_e0", 0, o_addr[0], 8'h3C);
    chk("fetch_grant_e0", 0, 8'(o_grant[0]), 8'h01);
    step();
    chk("fetch_ready_e1", 0, 8'(o_rdy[0][0]), 8'h00);
    step();
    chk("fetch_ready_e2", 0, 8'(o_rdy[0][0]), 8'h01);
    chk("fetch_rdata_e2", 0, o_rdata[0], 8'hA5);
    req_v[0][0] = 1'b0;
    step();
    chk("fetch_release", 0, 8'(o_rdy[0][0]), 8'h00);

    // Exec write: we high exactly two cycles, low when ready rises
    addr_v[0][1] = 8'h80; wd_v[0][1] = 8'h5A; we_v[0][1] = 1'b1; req_v[0][1] = 1'b1;
    cnt_we = 0; seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (o_we[0]) begin
        cnt_we++;
        chk("write_data_out", 0, o_dout[0], 8'h5A);
      end
      if (o_rdy[0][1]) begin
        seen = 1;
        chk("write_we_at_ready", 0, 8'(o_we[0]), 8'h00);
      end
    end
    chk("write_ready_seen", 0, 8'(seen), 8'h01);
    chk("write_we_cycles", 0, 8'(cnt_we), 8'h02);
    req_v[0][1] = 1'b0; we_v[0][1] = 1'b0;
    step();
    chk("write_release", 0, 8'(o_rdy[0][1]), 8'h00);

    // Reset in the middle of a write access
    addr_v[0][1] = 8'h10; we_v[0][1] = 1'b1; req_v[0][1] = 1'b1;
    step();
    chk("abort_we_before", 0, 8'(o_we[0]), 8'h01);
    rst = 1'b1;
    step();
    chk("abort_we", 0, 8'(o_we[0]), 8'h00);
    chk("abort_grant", 0, 8'(o_grant[0]), 8'h00);
    chk("abort_ready", 0, 8'(o_rdy[0][1]), 8'h00);
    chk("abort_addr", 0, o_addr[0], 8'h00);
    rst = 1'b0; req_v[0][1] = 1'b0; we_v[0][1] = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (o_rdy[0] != 3'b000) seen = 1;
    end
    chk("abort_no_ready", 0, 8'(seen), 8'h00);

    // Contention: fetch, exec, dbg, fetch, exec, dbg
    reset_all();
    glog0.delete();
    for (int i = 0; i < 3; i++) begin
      req_v[0][i] = 1'b1; addr_v[0][i] = 8'(8'h20 + i); wd_v[0][i] = 8'(8'h40 + i);
    end
    for (int n = 0; n < 80 && glog0.size() < 6; n++) begin
      step();
      for (int i = 0; i < 3; i++) react(0, i);
    end
    for (int i = 0; i < 6; i++)
      chk("rr_order", 0, (i < glog0.size()) ? 8'(glog0[i]) : 8'h00, 8'(exp_order[i]));

    // Starvation: fetch keeps asking, dbg asks once and is served next
    reset_all();
    glog0.delete();
    req_v[0][0] = 1'b1; addr_v[0][2] = 8'hD0;
    step();
    req_v[0][2] = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      react(0, 0);
      if (o_rdy[0][2]) begin
        seen = 1; req_v[0][2] = 1'b0;
      end
    end
    chk("starve_dbg_ready", 0, 8'(seen), 8'h01);
    chk("starve_first", 0, (glog0.size() > 0) ? 8'(glog0[0]) : 8'h00, 8'h01);
    chk("starve_second", 0, (glog0.size() > 1) ? 8'(glog0[1]) : 8'h00, 8'h04);
    req_v[0][0] = 1'b0;
    for (int n = 0; n < 6; n++) step();

    // WAIT_STATES=0 instance: ready after E1, back-to-back every 3 cycles
    reset_all();
    glog1.delete(); gt1.delete();
    addr_v[1][1] = 8'h01; din_v[1] = 8'h3E; req_v[1][1] = 1'b1;
    step();
    chk("ws0_grant_e0", 1, 8'(o_grant[1]), 8'h02);
    chk("ws0_ready_e0", 1, 8'(o_rdy[1][1]), 8'h00);
    react(1, 1);
    step();
    chk("ws0_ready_e1", 1, 8'(o_rdy[1][1]), 8'h01);
    chk("ws0_rdata_e1", 1, o_rdata[1], 8'h3E);
    react(1, 1);
    for (int n = 0; n < 10; n++) begin
      step();
      react(1, 1);
    end
    chk("ws0_period_a", 1, (gt1.size() > 1) ? 8'(gt1[1] - gt1[0]) : 8'h00, 8'h03);
    chk("ws0_period_b", 1, (gt1.size() > 2) ? 8'(gt1[2] - gt1[1]) : 8'h00, 8'h03);

    // Randomized traffic on both instances against the model
    clear_stim();
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        din_v[d] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
          req_v[d][i]  = ($urandom_range(0, 3) != 0);
          addr_v[d][i] = 8'($urandom);
          we_v[d][i]   = (i != 0) && ($urandom_range(0, 1) == 1);
          wd_v[d][i]   = 8'($urandom);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    clear_stim();
    for (int n = 0; n < 8; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-requester arbiter and sequencer for the single 8-bit memory bus. It shares the bus between instruction fetch, the execute stage, and the debug/loader port. Grants are round-robin so no requester can starve another. Each access runs for a parameterised number of wait states, and the requester is told when its access is complete through a 4-phase req/ready handshake.

## Interface
- WAIT_STATES, 1: extra bus cycles per access beyond the minimum one; legal range 0..7.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch request; read-only.
- fetch_addr  in  8  fetch address.
- exec_req  in  1  execute-stage request.
- exec_addr  in  8  execute address.
- exec_we  in  1  1 = write, 0 = read.
- exec_wdata  in  8  execute write data.
- dbg_req  in  1  debug port request.
- dbg_addr  in  8  debug address.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_wdata  in  8  debug write data.
- data_in  in  8  memory read data.
- addr  out  8  memory address.
- data_out  out  8  memory write data.
- we  out  1  memory write enable.
- rdata  out  8  read data captured for the current owner; shared by all requesters.
- fetch_ready, exec_ready, dbg_ready  out  1 each  access-complete indication to the owner.
- grant  out  3  one-hot owner, bit order {dbg, exec, fetch}; 0 when idle.

## Operation
- State machine states:
  - IDLE: no owner.
  - ACCESS: bus driven; wait counter runs.
  - DONE: ready is high; waiting for the owner to drop req.
- IDLE, one or more req high:
  - Select the owner round-robin, searching from the requester after last_grant in the order fetch→exec→dbg→fetch.
  - Latch the owner's addr into addr, wdata into data_out (fetch drives data_out=0), and we into we (fetch drives we=0).
  - Set grant, clear cnt, update last_grant, go to ACCESS.
- IDLE, no req: hold; we=0, grant=0, all ready=0.
- ACCESS:
  - If cnt < WAIT_STATES: cnt++.
  - Otherwise: rdata<=data_in (also captured on writes), owner ready<=1, we<=0, go to DONE.
- DONE:
  - When the owner's req is low: owner ready<=0, grant<=0, go to IDLE.
  - Until then hold all outputs.
- Bus isolation: addr, data_out and we change only on the IDLE→ACCESS edge and the we clear on the ACCESS→DONE edge. Requester inputs are ignored while not owner or outside IDLE.
- A non-owner req that drops before it is granted produces no access.
- last_grant reset value is dbg, so the first contest goes to fetch.
- cnt is 3 bits wide.

## Timing
- Reset values:
  - Outputs: addr=0, data_out=0, we=0, rdata=0, all ready=0, grant=0.
  - Internal: state=IDLE, cnt=0, last_grant=dbg.
- Reset mid-access aborts the access. we drops on the reset edge; no ready is issued.
- Latency: req high before edge E0, accepted in IDLE.
  - Bus driven from E0.
  - ready high after edge E(WAIT_STATES+1). With default WAIT_STATES=1, that is after E2.
  - rdata is valid in the same cycle ready rises.
- we is high for exactly WAIT_STATES+1 cycles per write.
- Release: owner drops req before edge Er → ready low after Er, state IDLE. The next grant happens at edge Er+1 at the earliest.
  - Minimum back-to-back period per access is WAIT_STATES+3 cycles.
- The owner must hold req, addr, we and wdata stable until it sees ready. Values changed while in ACCESS have no effect.
- Owner holding req high after ready: the bus stays allocated indefinitely in DONE. There is no timeout.

## Test plan
- Reset: assert rst during a write's ACCESS with exec_addr=0x10, exec_we=1 → next cycle we=0, grant=0, exec_ready=0, addr=0; no ready ever pulses.
- Single fetch read, WAIT_STATES=1: fetch_addr=0x3C, data_in=0xA5 → addr=0x3C after E0; fetch_ready=1 and rdata=0xA5 after E2; fetch_ready=0 one cycle after fetch_req drops.
- Exec write: exec_addr=0x80, exec_wdata=0x5A, exec_we=1 → we=1 for exactly 2 cycles with data_out=0x5A; we=0 in the same cycle exec_ready rises.
- Contention: all three req high from reset, each client dropping req on its ready and re-raising it immediately → grant order fetch, exec, dbg, fetch, exec, dbg.
- Starvation check: fetch_req held continuously (re-raised each cycle after ready) with dbg_req raised once → dbg is granted at the first IDLE after the current fetch access completes.
- WAIT_STATES=0 build: exec read at 0x01 → exec_ready high after E1; back-to-back accesses every 3 cycles.
